// File: rtl/cordic_arbiter_pkg.sv
// Shared widths, Q7.8 constants and result-record sizing
// for the CORDIC pipeline arbiter slice.
package cordic_arbiter_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_SECTOR_WIDTH = 2;
    localparam int DEF_PIPE_LATENCY = 6;

    localparam int Q_INT_BITS  = 7;
    localparam int Q_FRAC_BITS = 8;
    localparam logic [DEF_DATA_WIDTH-1:0] Q_ONE = 16'h0100;

    function automatic int rec_width(input int dw, input int sw);
        return 3 * dw + sw + 1;
    endfunction

    localparam int DEF_REC_WIDTH = rec_width(DEF_DATA_WIDTH, DEF_SECTOR_WIDTH);

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Per-requester result FIFO; DEPTH is a power of two so pointers wrap
// naturally. Output data holds the last popped word while empty.
module cordic_rsp_fifo
    import cordic_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_REC_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] hold_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign data   = valid ? mem[rd_ptr] : hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                hold_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    // Credits make this unreachable; a hit means the credit loop is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !do_pop && count == FULL));

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin, credit-based sharing of one CORDIC pipeline between
// NUM_REQ requesters with ID-tagged result routing.
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int SECTOR_WIDTH = DEF_SECTOR_WIDTH,
    parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
    parameter int CREDITS      = 4,
    parameter int ID_WIDTH     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_degree,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_y,
    input  logic [NUM_REQ*SECTOR_WIDTH-1:0]  req_sector,
    input  logic [NUM_REQ-1:0]               req_arctan_en,
    output logic                             pipe_valid_in,
    output logic                             pipe_arctan_en_in,
    output logic [DATA_WIDTH-1:0]            pipe_degree_in,
    output logic [DATA_WIDTH-1:0]            pipe_x_in,
    output logic [DATA_WIDTH-1:0]            pipe_y_in,
    output logic [SECTOR_WIDTH-1:0]          pipe_sector_in,
    input  logic                             pipe_valid_out,
    input  logic                             pipe_arctan_en_out,
    input  logic [DATA_WIDTH-1:0]            pipe_degree_out,
    input  logic [DATA_WIDTH-1:0]            pipe_x_out,
    input  logic [DATA_WIDTH-1:0]            pipe_y_out,
    input  logic [SECTOR_WIDTH-1:0]          pipe_sector_out,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_degree,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_x,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_y,
    output logic [NUM_REQ*SECTOR_WIDTH-1:0]  rsp_sector,
    output logic [NUM_REQ-1:0]               rsp_arctan_en,
    output logic                             busy,
    output logic                             tag_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int RW = rec_width(DATA_WIDTH, SECTOR_WIDTH);
    localparam int DW = DATA_WIDTH;
    localparam int SW = SECTOR_WIDTH;
    localparam int PL = PIPE_LATENCY;

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  rsp_pop;
    logic [NUM_REQ-1:0]  fifo_push;
    logic                accept;
    logic                fifo_wr;
    logic [ID_WIDTH-1:0] gnt_id;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] id_q;
    logic [CW-1:0]       credit [NUM_REQ];
    logic [PL-1:0]       tag_v;
    logic [ID_WIDTH-1:0] tag_id [PL];
    logic [RW-1:0]       pipe_rec;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = reset && en && req_valid[i] && (credit[i] != '0);
    end

    // Search starts one past the last winner and wraps.
    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        grant  = '0;
        gnt_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = ID_WIDTH'(idx);
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign rsp_pop   = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= ID_WIDTH'(NUM_REQ - 1);
            id_q              <= '0;
            pipe_valid_in     <= 1'b0;
            pipe_arctan_en_in <= 1'b0;
            pipe_degree_in    <= '0;
            pipe_x_in         <= '0;
            pipe_y_in         <= '0;
            pipe_sector_in    <= '0;
        end else begin
            pipe_valid_in <= accept;
            if (accept) begin
                rr_ptr            <= gnt_id;
                id_q              <= gnt_id;
                pipe_arctan_en_in <= req_arctan_en[gnt_id];
                pipe_degree_in    <= req_degree[int'(gnt_id)*DW +: DW];
                pipe_x_in         <= req_x[int'(gnt_id)*DW +: DW];
                pipe_y_in         <= req_y[int'(gnt_id)*DW +: DW];
                pipe_sector_in    <= req_sector[int'(gnt_id)*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) credit[i] <= CW'(CREDITS);
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !rsp_pop[i]) credit[i] <= credit[i] - 1'b1;
                else if (!grant[i] && rsp_pop[i]) credit[i] <= credit[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v   <= '0;
            tag_err <= 1'b0;
            for (int j = 0; j < PL; j++) tag_id[j] <= '0;
        end else begin
            tag_v[0]  <= pipe_valid_in;
            tag_id[0] <= id_q;
            for (int j = 1; j < PL; j++) begin
                tag_v[j]  <= tag_v[j-1];
                tag_id[j] <= tag_id[j-1];
            end
            if (tag_v[PL-1] != pipe_valid_out) tag_err <= 1'b1;
        end
    end

    assign fifo_wr  = pipe_valid_out && tag_v[PL-1];
    assign pipe_rec = {pipe_arctan_en_out, pipe_sector_out,
                       pipe_degree_out, pipe_x_out, pipe_y_out};
    assign busy     = pipe_valid_in || (|tag_v) || (|rsp_valid);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        logic [RW-1:0] rd;

        assign fifo_push[g] = fifo_wr && (tag_id[PL-1] == ID_WIDTH'(g));

        cordic_rsp_fifo #(
            .WIDTH (RW),
            .DEPTH (CREDITS)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[g]),
            .push_data (pipe_rec),
            .pop       (rsp_ready[g]),
            .valid     (rsp_valid[g]),
            .data      (rd)
        );

        assign {rsp_arctan_en[g], rsp_sector[g*SW +: SW],
                rsp_degree[g*DW +: DW], rsp_x[g*DW +: DW],
                rsp_y[g*DW +: DW]} = rd;
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboarded bench for cordic_arbiter with a behavioural
// fixed-latency pipeline model on the pipe_* ports.
module tb_cordic_arbiter;
    import cordic_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int L  = 6;
    localparam int RW = 3 * DW + SW + 1;

    logic              clk;
    logic              reset;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_degree;
    logic [N*DW-1:0]   req_x;
    logic [N*DW-1:0]   req_y;
    logic [N*SW-1:0]   req_sector;
    logic [N-1:0]      req_arctan_en;
    logic              pipe_valid_in;
    logic              pipe_arctan_en_in;
    logic [DW-1:0]     pipe_degree_in;
    logic [DW-1:0]     pipe_x_in;
    logic [DW-1:0]     pipe_y_in;
    logic [SW-1:0]     pipe_sector_in;
    logic              pipe_valid_out;
    logic              pipe_arctan_en_out;
    logic [DW-1:0]     pipe_degree_out;
    logic [DW-1:0]     pipe_x_out;
    logic [DW-1:0]     pipe_y_out;
    logic [SW-1:0]     pipe_sector_out;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [N*DW-1:0]   rsp_degree;
    logic [N*DW-1:0]   rsp_x;
    logic [N*DW-1:0]   rsp_y;
    logic [N*SW-1:0]   rsp_sector;
    logic [N-1:0]      rsp_arctan_en;
    logic              busy;
    logic              tag_err;

    int checks = 0;
    int errors = 0;
    int acc [N];
    int pops [N];
    int last_gnt;
    int rr_model;
    logic [RW-1:0] sb0 [$];
    logic [RW-1:0] sb1 [$];
    logic [RW:0]   pq [$];

    cordic_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .SECTOR_WIDTH (SW),
        .PIPE_LATENCY (L),
        .CREDITS      (4),
        .ID_WIDTH     (1)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .en                 (en),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_degree         (req_degree),
        .req_x              (req_x),
        .req_y              (req_y),
        .req_sector         (req_sector),
        .req_arctan_en      (req_arctan_en),
        .pipe_valid_in      (pipe_valid_in),
        .pipe_arctan_en_in  (pipe_arctan_en_in),
        .pipe_degree_in     (pipe_degree_in),
        .pipe_x_in          (pipe_x_in),
        .pipe_y_in          (pipe_y_in),
        .pipe_sector_in     (pipe_sector_in),
        .pipe_valid_out     (pipe_valid_out),
        .pipe_arctan_en_out (pipe_arctan_en_out),
        .pipe_degree_out    (pipe_degree_out),
        .pipe_x_out         (pipe_x_out),
        .pipe_y_out         (pipe_y_out),
        .pipe_sector_out    (pipe_sector_out),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_degree         (rsp_degree),
        .rsp_x              (rsp_x),
        .rsp_y              (rsp_y),
        .rsp_sector         (rsp_sector),
        .rsp_arctan_en      (rsp_arctan_en),
        .busy               (busy),
        .tag_err            (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in pipeline transform.
    function automatic logic [RW-1:0] xform(input logic [RW-1:0] r);
        logic a;
        logic [SW-1:0] s;
        logic [DW-1:0] d, x, y;
        {a, s, d, x, y} = r;
        return {a, s, d + 16'h0100, y, ~x};
    endfunction

    function automatic logic [RW-1:0] req_rec(input int i);
        return {req_arctan_en[i], req_sector[i*SW +: SW],
                req_degree[i*DW +: DW], req_x[i*DW +: DW], req_y[i*DW +: DW]};
    endfunction

    function automatic logic [RW-1:0] rsp_rec(input int i);
        return {rsp_arctan_en[i], rsp_sector[i*SW +: SW],
                rsp_degree[i*DW +: DW], rsp_x[i*DW +: DW], rsp_y[i*DW +: DW]};
    endfunction

    task automatic set_op(input int i, input logic [DW-1:0] d,
                          input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [SW-1:0] s, input logic a);
        req_degree[i*DW +: DW] = d;
        req_x[i*DW +: DW]      = x;
        req_y[i*DW +: DW]      = y;
        req_sector[i*SW +: SW] = s;
        req_arctan_en[i]       = a;
    endtask

    task automatic observe();
        logic [RW-1:0] exp;
        last_gnt = -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                last_gnt = i;
                rr_model = i;
                acc[i]++;
                if (i == 0) sb0.push_back(xform(req_rec(i)));
                else sb1.push_back(xform(req_rec(i)));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                pops[i]++;
                if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
                    check($sformatf("sb_empty%0d", i), 64'd1, 64'd0);
                end else begin
                    exp = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("rsp%0d", i), 64'(rsp_rec(i)), 64'(exp));
                end
            end
        end
    endtask

    task automatic pipe_step();
        logic [RW:0] e;
        logic [RW-1:0] r;
        if (!reset) begin
            pq.delete();
            for (int k = 0; k < L; k++) pq.push_back('0);
            e = '0;
        end else begin
            pq.push_back({pipe_valid_in, pipe_arctan_en_in, pipe_sector_in,
                          pipe_degree_in, pipe_x_in, pipe_y_in});
            e = pq.pop_front();
        end
        r = xform(e[RW-1:0]);
        pipe_valid_out = e[RW];
        {pipe_arctan_en_out, pipe_sector_out, pipe_degree_out,
         pipe_x_out, pipe_y_out} = r;
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
        pipe_step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            acc[i]  = 0;
            pops[i] = 0;
        end
    endtask

    initial begin
        int lat;
        int prev;
        int cnt;
        reset          = 1'b0;
        en             = 1'b0;
        req_valid      = '0;
        req_degree     = '0;
        req_x          = '0;
        req_y          = '0;
        req_sector     = '0;
        req_arctan_en  = '0;
        rsp_ready      = '0;
        rr_model       = N - 1;
        clr_counts();
        for (int k = 0; k < L; k++) pq.push_back('0);
        pipe_step();
        repeat (3) tick();

        en = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_pvin", 64'(pipe_valid_in), 64'd0);
        check("rst_rspv", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tagerr", 64'(tag_err), 64'd0);
        check("rst_pdeg", 64'(pipe_degree_in), 64'd0);
        req_valid = '0;
        reset = 1'b1;
        tick();

        // single rotation op
        rsp_ready = 2'b11;
        set_op(0, 16'h2D00, 16'h0000, 16'h0000, 2'b01, 1'b0);
        req_valid = 2'b01;
        #1;
        check("single_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        check("single_pvin", 64'(pipe_valid_in), 64'd1);
        check("single_pdeg", 64'(pipe_degree_in), 64'h2D00);
        lat = 1;
        while (!rsp_valid[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("single_lat", 64'(lat), 64'd8);
        tick();
        wait_idle();

        // both requesters streaming
        prev = rr_model;
        cnt = 0;
        req_valid = 2'b11;
        for (int c = 0; c < 16; c++) begin
            set_op(0, 16'(c * 256), 16'(c), 16'h1000, 2'(c), c[0]);
            set_op(1, 16'(c * 256 + 128), 16'(c + 7), 16'h2000, 2'(c + 1), ~c[0]);
            tick();
            if (last_gnt >= 0) begin
                check($sformatf("alt%0d", c), 64'(last_gnt), 64'(prev ^ 1));
                prev = last_gnt;
                cnt++;
            end
        end
        check("alt_some", 64'(cnt >= 10), 64'd1);
        req_valid = '0;
        wait_idle();
        check("alt_tagerr", 64'(tag_err), 64'd0);

        // req1 with no result pops runs out of credit
        clr_counts();
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        for (int c = 0; c < 12; c++) begin
            set_op(1, 16'(16'h4000 + c), 16'(c), 16'(c * 3), 2'b10, 1'b1);
            tick();
        end
        check("cred_acc1", 64'(acc[1]), 64'd4);
        #1;
        check("cred_block1", 64'(req_ready[1]), 64'd0);
        clr_counts();
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            set_op(0, 16'(16'h0500 + c), 16'(c), 16'h0001, 2'b11, 1'b0);
            tick();
        end
        check("cred_acc0", 64'(acc[0]), 64'd4);
        check("cred_acc1b", 64'(acc[1]), 64'd0);
        req_valid = '0;
        repeat (12) tick();
        check("cred_full1", 64'(rsp_valid[1]), 64'd1);

        // pop/accept at the credit-0 boundary
        rsp_ready = 2'b11;
        req_valid = 2'b10;
        set_op(1, 16'h7100, 16'h0011, 16'h0022, 2'b00, 1'b1);
        #1;
        check("bnd_zero", 64'(req_ready[1]), 64'd0);
        tick();
        #1;
        check("bnd_one", 64'(req_ready[1]), 64'd1);
        tick();
        set_op(1, 16'h7200, 16'h0033, 16'h0044, 2'b01, 1'b0);
        rsp_ready = 2'b01;
        #1;
        check("bnd_keep", 64'(req_ready[1]), 64'd1);
        tick();
        #1;
        check("bnd_empty", 64'(req_ready[1]), 64'd0);
        req_valid = '0;
        rsp_ready = 2'b11;
        wait_idle();

        // en drops after three issues
        clr_counts();
        req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            set_op(0, 16'(16'h1100 * (c + 1)), 16'(c), 16'(c), 2'(c), 1'b0);
            tick();
        end
        en = 1'b0;
        check("en_busy", 64'(busy), 64'd1);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (pipe_valid_in) cnt++;
        end
        check("en_ready", 64'(req_ready), 64'd0);
        check("en_acc", 64'(acc[0]), 64'd3);
        check("en_pvin", 64'(cnt), 64'd0);
        req_valid = '0;
        wait_idle();
        check("en_pops", 64'(pops[0]), 64'd3);

        // reset with ops in flight
        en = 1'b1;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            set_op(0, 16'(16'h6000 + c), 16'h0F0F, 16'(c), 2'b11, 1'b1);
            tick();
        end
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        reset = 1'b0;
        sb0.delete();
        sb1.delete();
        rr_model = N - 1;
        req_valid = 2'b01;
        #1;
        check("mid_ready", 64'(req_ready), 64'd0);
        check("mid_pvin", 64'(pipe_valid_in), 64'd0);
        check("mid_rspv", 64'(rsp_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_pdeg", 64'(pipe_degree_in), 64'd0);
        req_valid = '0;
        tick();
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (rsp_valid != '0) cnt++;
        end
        check("mid_stale", 64'(cnt), 64'd0);
        check("mid_tagerr", 64'(tag_err), 64'd0);
        clr_counts();
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        for (int c = 0; c < 8; c++) begin
            set_op(0, 16'(16'h3000 + c), 16'(c), 16'(c), 2'b01, 1'b0);
            tick();
        end
        check("mid_credits", 64'(acc[0]), 64'd4);
        req_valid = '0;
        rsp_ready = 2'b11;
        wait_idle();

        check("end_sb0", 64'(sb0.size()), 64'd0);
        check("end_sb1", 64'(sb1.size()), 64'd0);
        check("end_tagerr", 64'(tag_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
